// File: rtl/axi4s_pkg.sv
// Shared AXI4-Stream definitions for the switch ingress/egress blocks:
// sideband widths, arbiter state encoding and the registered beat payload.
package axi4s_pkg;

    localparam int AXI4S_DATA_W = 8;
    localparam int AXI4S_ID_W   = 4;
    localparam int AXI4S_DEST_W = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    typedef struct packed {
        logic [AXI4S_DATA_W-1:0] data;
        logic                    strb;
        logic                    keep;
        logic                    last;
        logic [AXI4S_DEST_W-1:0] dest;
        logic                    user;
    } axi4s_beat_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: returns the first requester after ptr_i,
// wrapping modulo N_PORTS, so ptr_i itself has the lowest priority.
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N_PORTS);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/axi4s_pkt_arbiter.sv
// N-input to 1-output AXI4-Stream packet arbiter: one input owns the output
// from its first beat through tlast, with round-robin between packets.
module axi4s_pkt_arbiter
    import axi4s_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = $clog2(N_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PORTS-1:0]   s_tvalid,
    output logic [N_PORTS-1:0]   s_tready,
    input  logic [8*N_PORTS-1:0] s_tdata,
    input  logic [N_PORTS-1:0]   s_tstrb,
    input  logic [N_PORTS-1:0]   s_tkeep,
    input  logic [N_PORTS-1:0]   s_tlast,
    input  logic [4*N_PORTS-1:0] s_tdest,
    input  logic [N_PORTS-1:0]   s_tuser,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tstrb,
    output logic                 m_tkeep,
    output logic                 m_tlast,
    output logic [3:0]           m_tid,
    output logic [3:0]           m_tdest,
    output logic                 m_tuser
);

    arb_state_e              state_q;
    logic [IDX_W-1:0]        grant_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    axi4s_beat_t             out_q;
    logic                    m_tvalid_q;
    logic [AXI4S_ID_W-1:0]   m_tid_q;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    axi4s_beat_t             sel_beat;
    logic                    out_free;
    logic                    accept;

    rr_pick #(
        .N_PORTS(N_PORTS),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req_i  (s_tvalid),
        .ptr_i  (rr_ptr_q),
        .found_o(pick_found),
        .idx_o  (pick_idx)
    );

    always_comb begin
        sel_beat = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_beat.data = s_tdata[i*8 +: 8];
                sel_beat.strb = s_tstrb[i];
                sel_beat.keep = s_tkeep[i];
                sel_beat.last = s_tlast[i];
                sel_beat.dest = s_tdest[i*4 +: 4];
                sel_beat.user = s_tuser[i];
            end
        end
    end

    // A beat transfers on any side exactly when valid and ready are both high on a
    // rising edge; the output register can take a new beat when it is empty or
    // draining in the same cycle, so only the granted input ever sees ready.
    assign out_free = !m_tvalid_q || m_tready;

    always_comb begin
        s_tready = '0;
        if (state_q == ARB_LOCKED) begin
            for (int i = 0; i < N_PORTS; i++) begin
                s_tready[i] = (grant_q == IDX_W'(i)) && out_free;
            end
        end
    end

    assign accept = |(s_tvalid & s_tready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= IDX_W'(N_PORTS - 1);
            out_q      <= '0;
            m_tvalid_q <= 1'b0;
            m_tid_q    <= '0;
        end else begin
            if (accept) begin
                out_q      <= sel_beat;
                m_tvalid_q <= 1'b1;
                m_tid_q    <= AXI4S_ID_W'(grant_q);
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    // Grant is released only by an accepted tlast beat.
                    if (accept && sel_beat.last) begin
                        rr_ptr_q <= grant_q;
                        state_q  <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = out_q.data;
    assign m_tstrb  = out_q.strb;
    assign m_tkeep  = out_q.keep;
    assign m_tlast  = out_q.last;
    assign m_tid    = m_tid_q;
    assign m_tdest  = out_q.dest;
    assign m_tuser  = out_q.user;

endmodule

// File: tb/tb_axi4s_pkt_arbiter.sv
// Self-checking bench for axi4s_pkt_arbiter: arbitration vector table,
// scripted corner sequences and randomized traffic against a packet-level model.
module tb_axi4s_pkt_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   s_tvalid, s_tready, s_tstrb, s_tkeep, s_tlast, s_tuser;
    logic [8*N-1:0] s_tdata;
    logic [4*N-1:0] s_tdest;
    logic           m_tvalid, m_tready, m_tstrb, m_tkeep, m_tlast, m_tuser;
    logic [7:0]     m_tdata;
    logic [3:0]     m_tid, m_tdest;

    always #5 clk = ~clk;

    axi4s_pkt_arbiter #(.N_PORTS(N)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       strb;
        logic       keep;
        logic       last;
        logic [3:0] dest;
        logic       user;
    } beat_t;

    typedef struct {
        int         prev;
        logic [3:0] mask;
        int         exp_tid;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [18:0] exp_q[$];
    beat_t       src_mem[N][64];
    int          src_len[N];
    int          src_pos[N];
    int          gap_cnt[N];
    int          gap_pct, ready_mode, force_port, force_beat, force_len;
    bit          check_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic l, input logic [3:0] dst, input logic u);
        beat_t b;
        b.data = d; b.strb = 1'b1; b.keep = 1'b1; b.last = l; b.dest = dst; b.user = u;
        return b;
    endfunction

    task automatic set_port(input int p, input beat_t b, input logic v);
        s_tvalid[p]       = v;
        s_tdata[p*8 +: 8] = b.data;
        s_tstrb[p]        = b.strb;
        s_tkeep[p]        = b.keep;
        s_tlast[p]        = b.last;
        s_tdest[p*4 +: 4] = b.dest;
        s_tuser[p]        = b.user;
    endtask

    task automatic clear_inputs();
        s_tvalid = '0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0;
        s_tlast = '0; s_tdest = '0; s_tuser = '0;
    endtask

    task automatic clear_sources();
        for (int p = 0; p < N; p++) begin
            src_len[p] = 0; src_pos[p] = 0; gap_cnt[p] = 0;
        end
        exp_q.delete();
        gap_pct = 0; ready_mode = 0; check_gap = 1'b0;
        force_port = -1; force_beat = 0; force_len = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        m_tready = 1'b1;
        clear_sources();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic add_pkt(input int p, input int len, input logic [3:0] dest, input logic user);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = 8'($urandom);
            b.strb = 1'($urandom);
            b.keep = 1'($urandom);
            b.last = (k == len - 1);
            b.dest = dest;
            b.user = user;
            src_mem[p][src_len[p]] = b;
            src_len[p] = src_len[p] + 1;
        end
    endtask

    // Whole packets leave in round-robin order among inputs that still have data.
    task automatic build_model();
        int    ptr;
        int    pos[N];
        int    found;
        int    c;
        beat_t b;
        ptr = N - 1;
        for (int p = 0; p < N; p++) pos[p] = 0;
        while (1) begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                c = (ptr + k) % N;
                if (found < 0 && pos[c] < src_len[c]) found = c;
            end
            if (found < 0) break;
            do begin
                b = src_mem[found][pos[found]];
                exp_q.push_back({4'(found), b});
                pos[found]++;
            end while (!b.last);
            ptr = found;
        end
    endtask

    task automatic drive_sources();
        for (int p = 0; p < N; p++) begin
            if (gap_cnt[p] == 0 && src_pos[p] < src_len[p]) set_port(p, src_mem[p][src_pos[p]], 1'b1);
            else set_port(p, '0, 1'b0);
        end
    endtask

    task automatic run_engine(input int budget);
        int           cyc;
        int           idle_run;
        bit           prev_stall, last_was_last, done;
        logic [31:0]  snap_now, snap_prev;
        logic [18:0]  e;
        logic [N-1:0] hs, other;
        cyc = 0; idle_run = 0; prev_stall = 0; last_was_last = 0; snap_prev = '0;
        m_tready = 1'b1;
        drive_sources();
        while (cyc < budget) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !m_tvalid;
            for (int p = 0; p < N; p++) if (src_pos[p] < src_len[p]) done = 0;
            if (done) break;
            hs = s_tvalid & s_tready;
            snap_now = {11'd0, m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
            if (prev_stall) check("hold_stable", snap_now, snap_prev);
            if (m_tvalid && !m_tready) check("stall_ready", 32'(s_tready), 32'd0);
            for (int p = 0; p < N; p++) begin
                if (src_pos[p] > 0 && src_pos[p] < src_len[p] && !src_mem[p][src_pos[p]-1].last) begin
                    other = '1;
                    other[p] = 1'b0;
                    check($sformatf("lock_p%0d", p), 32'(s_tready & other), 32'd0);
                end
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("beat", {13'd0, m_tid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tdest, m_tuser},
                          {13'd0, e});
                end
                if (check_gap && last_was_last) check("pkt_gap", 32'(idle_run), 32'd1);
                last_was_last = m_tlast;
                idle_run = 0;
            end else if (!m_tvalid) idle_run++;
            prev_stall = m_tvalid && !m_tready;
            snap_prev = snap_now;
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (hs[p]) begin
                    src_pos[p]++;
                    if (!src_mem[p][src_pos[p]-1].last) begin
                        if (p == force_port && src_pos[p] == force_beat) gap_cnt[p] = force_len;
                        else if ($urandom_range(0, 99) < gap_pct) gap_cnt[p] = $urandom_range(1, 3);
                    end
                end else if (gap_cnt[p] > 0) gap_cnt[p]--;
            end
            drive_sources();
            case (ready_mode)
                1:       m_tready = ~m_tready;
                2:       m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = 1'b1;
            endcase
            cyc++;
        end
        check("engine_done", 32'(cyc < budget), 32'd1);
        check("exp_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        bit seen;
        seen = 0;
        do_reset();
        set_port(v.prev, mk(8'hE0, 1'b1, 4'h0, 1'b0), 1'b1);
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = s_tvalid[v.prev] && s_tready[v.prev];
            @(posedge clk);
            #1;
        end
        check($sformatf("v%0d_setup", idx), 32'(seen), 32'd1);
        clear_inputs();
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < N; i++) if (v.mask[i]) set_port(i, mk(8'(8'h50 + i), 1'b1, 4'(i), 1'b0), 1'b1);
        @(negedge clk);
        check($sformatf("v%0d_idle_ready", idx), 32'(s_tready), 32'd0);
        @(posedge clk); #1; @(negedge clk);
        check($sformatf("v%0d_grant", idx), 32'(s_tready), 32'(1 << v.exp_tid));
        check($sformatf("v%0d_early_valid", idx), 32'(m_tvalid), 32'd0);
        @(posedge clk); #1; @(negedge clk);
        check($sformatf("v%0d_valid", idx), 32'(m_tvalid), 32'd1);
        check($sformatf("v%0d_tid", idx), 32'(m_tid), 32'(v.exp_tid));
        check($sformatf("v%0d_data", idx), 32'(m_tdata), 32'(8'h50 + v.exp_tid));
        clear_inputs();
    endtask

    vec_t vecs[8];

    initial begin
        // {input that sent the previous packet, valid mask, expected winner}
        vecs[0] = '{0, 4'b1111, 1};
        vecs[1] = '{1, 4'b1111, 2};
        vecs[2] = '{3, 4'b1111, 0};
        vecs[3] = '{2, 4'b0011, 0};
        vecs[4] = '{0, 4'b0001, 0};
        vecs[5] = '{1, 4'b1001, 3};
        vecs[6] = '{3, 4'b1000, 3};
        vecs[7] = '{2, 4'b0100, 2};

        // Reset with random inputs, then a 3-beat packet on input 0.
        s_tvalid = 4'($urandom); s_tdata = 32'($urandom); s_tstrb = 4'($urandom);
        s_tkeep = 4'($urandom); s_tlast = 4'($urandom); s_tdest = 16'($urandom);
        s_tuser = 4'($urandom); m_tready = 1'($urandom);
        repeat (2) @(posedge clk);
        #2;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tid", 32'(m_tid), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        clear_inputs();
        m_tready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_port(0, mk(8'h11, 1'b0, 4'h0, 1'b0), 1'b1);
        @(negedge clk);
        check("s1_idle_ready", 32'(s_tready), 32'd0);
        @(posedge clk); #1; @(negedge clk);
        check("s1_grant_ready", 32'(s_tready), 32'd1);
        check("s1_c1_valid", 32'(m_tvalid), 32'd0);
        @(posedge clk); #1;
        set_port(0, mk(8'h22, 1'b0, 4'h0, 1'b0), 1'b1);
        @(negedge clk);
        check("s1_c2_valid", 32'(m_tvalid), 32'd1);
        check("s1_b0", {15'd0, m_tid, m_tdata, m_tlast}, {15'd0, 4'd0, 8'h11, 1'b0});
        @(posedge clk); #1;
        set_port(0, mk(8'h33, 1'b1, 4'h0, 1'b0), 1'b1);
        @(negedge clk);
        check("s1_b1", {15'd0, m_tid, m_tdata, m_tlast}, {15'd0, 4'd0, 8'h22, 1'b0});
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        check("s1_b2", {15'd0, m_tid, m_tdata, m_tlast}, {15'd0, 4'd0, 8'h33, 1'b1});
        @(posedge clk); #1; @(negedge clk);
        check("s1_drained", 32'(m_tvalid), 32'd0);

        for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

        // Fairness: every input offers three 2-beat packets back to back.
        do_reset();
        for (int p = 0; p < N; p++) for (int k = 0; k < 3; k++) add_pkt(p, 2, 4'(p), 1'b0);
        check_gap = 1'b1;
        build_model();
        run_engine(400);

        // Backpressure: 4-beat packet on input 2 with m_tready toggling.
        do_reset();
        add_pkt(2, 4, 4'h5, 1'b1);
        ready_mode = 1;
        build_model();
        run_engine(100);

        // Lock hold: input 1 stalls 5 cycles mid-packet while input 3 waits.
        do_reset();
        add_pkt(1, 4, 4'h1, 1'b0);
        add_pkt(3, 2, 4'h3, 1'b1);
        force_port = 1; force_beat = 2; force_len = 5;
        build_model();
        run_engine(100);

        // Single-beat packets on input 3 only, wrapping from the reset pointer.
        do_reset();
        for (int k = 0; k < 4; k++) add_pkt(3, 1, 4'hA, 1'b1);
        check_gap = 1'b1;
        build_model();
        run_engine(100);

        // Asynchronous reset between beats 2 and 3 of a 5-beat packet.
        do_reset();
        set_port(0, mk(8'h61, 1'b0, 4'h0, 1'b0), 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_port(0, mk(8'h62, 1'b0, 4'h0, 1'b0), 1'b1);
        @(posedge clk); #1;
        set_port(0, mk(8'h63, 1'b0, 4'h0, 1'b0), 1'b1);
        @(negedge clk);
        check("s6_pre_valid", 32'(m_tvalid), 32'd1);
        check("s6_pre_data", 32'(m_tdata), 32'h62);
        #2 rst = 1'b1;
        #1;
        check("s6_async_valid", 32'(m_tvalid), 32'd0);
        check("s6_async_ready", 32'(s_tready), 32'd0);
        clear_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sources();
        add_pkt(0, 1, 4'h7, 1'b0);
        add_pkt(2, 1, 4'h8, 1'b0);
        build_model();
        run_engine(100);

        // Randomized traffic with mid-packet source gaps and random backpressure.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int p = 0; p < N; p++) begin
                int npk;
                npk = $urandom_range(0, 4);
                for (int k = 0; k < npk; k++) add_pkt(p, $urandom_range(1, 4), 4'($urandom), 1'($urandom));
            end
            gap_pct = 30;
            ready_mode = 2;
            build_model();
            run_engine(2000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
